// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit and its datapath.
package uc_pkg;

   // Controller states, exposed on ESTADO_ATUAL for debug
   typedef enum logic [4:0] {
      RESET_ST = 5'd0,
      FETCH    = 5'd1,
      DECODE   = 5'd2,
      EXEC_R   = 5'd3,
      EXEC_I   = 5'd4,
      LUI      = 5'd5,
      WB_ALU   = 5'd6,
      ADDR     = 5'd7,
      MEM_RD   = 5'd8,
      WB_MEM   = 5'd9,
      MEM_WR   = 5'd10,
      BRANCH   = 5'd11,
      JAL      = 5'd12,
      TRAP     = 5'd13
   } uc_state_e;

   // Opcodes (IR[6:0])
   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_I      = 7'd19;
   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_JAL    = 7'd111;

   localparam logic [6:0] F7_ADD = 7'd0;
   localparam logic [6:0] F7_SUB = 7'd32;

   // ALU operation select
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;

   // ALU operand muxes
   localparam logic [1:0] SRCA_PC      = 2'd0;
   localparam logic [1:0] SRCA_A       = 2'd1;
   localparam logic [1:0] SRCA_ZERO    = 2'd2;
   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_4       = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH1 = 2'd3;

   // Register write-back source
   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MDR = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   // PC source
   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_TRAP   = 2'd2;

   // States that hold a memory request open and wait for MEM_READY
   function automatic logic is_mem_state(input uc_state_e s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/uc_mem_wait.sv
// Memory wait counter: counts not-ready cycles of one access and flags a timeout.
module uc_mem_wait #(
   parameter int unsigned MEM_TO_MAX = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,      // next cycle begins a new access
   input  logic active_i,     // a memory access is pending this cycle
   input  logic mem_ready_i,
   output logic timeout_o     // this is the last allowed not-ready cycle
);

   localparam logic [7:0] LAST = 8'(MEM_TO_MAX - 1);

   logic [7:0] cnt_q, cnt_d;

   // Timeout fires on the MEM_TO_MAX-th not-ready cycle; a ready on that cycle wins
   assign timeout_o = active_i && !mem_ready_i && (cnt_q == LAST);

   // Next count: clear on access entry, else count not-ready cycles
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (active_i && !mem_ready_i && !timeout_o) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uc_multiciclo_param.sv
// Multicycle control FSM for the RV64 subset datapath.
module uc_multiciclo_param
   import uc_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned MEM_TO_MAX = 15,
   parameter bit          EN_JAL     = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] IR31_0,
   input  logic        Igual,
   input  logic        MEM_READY,
   output logic        PC_WRITE,
   output logic [1:0]  PC_SRC,
   output logic        IR_WIRE,
   output logic        MEM_REQ,
   output logic        DMEM_RW,
   output logic        LOAD_AB,
   output logic [1:0]  ALU_SRCA,
   output logic [1:0]  ALU_SRCB,
   output logic [2:0]  ALU_SELECTOR,
   output logic        LOAD_ALU_OUT,
   output logic        LOAD_MDR,
   output logic        WRITE_REG,
   output logic [1:0]  MEM_TO_REG,
   output logic [4:0]  ESTADO_ATUAL,
   output logic        ILLEGAL,
   output logic        MEM_TIMEOUT
);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("uc_multiciclo_param: XLEN must be 32 or 64");
   end

   uc_state_e state_q, state_d;
   logic      illegal_q, illegal_d;
   logic      timeout_q, timeout_d;
   logic      mem_to;
   logic      mem_start;

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       unused_ir;

   assign opcode    = IR31_0[6:0];
   assign funct3    = IR31_0[14:12];
   assign funct7    = IR31_0[31:25];
   assign unused_ir = ^{IR31_0[24:15], IR31_0[11:7]};

   assign ESTADO_ATUAL = state_q;
   assign ILLEGAL      = illegal_q;
   assign MEM_TIMEOUT  = timeout_q;

   // A new access starts whenever we move into a request state from elsewhere
   assign mem_start = (state_d != state_q) && is_mem_state(state_d);

   uc_mem_wait #(.MEM_TO_MAX(MEM_TO_MAX)) u_wait (
      .clk_i      (CLK),
      .rst_ni     (RESET_N),
      .start_i    (mem_start),
      .active_i   (is_mem_state(state_q)),
      .mem_ready_i(MEM_READY),
      .timeout_o  (mem_to)
   );

   // Next-state and datapath controls decoded from the current state
   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      timeout_d    = timeout_q;
      PC_WRITE     = 1'b0;
      PC_SRC       = PCS_ALU;
      IR_WIRE      = 1'b0;
      MEM_REQ      = 1'b0;
      DMEM_RW      = 1'b0;
      LOAD_AB      = 1'b0;
      ALU_SRCA     = SRCA_PC;
      ALU_SRCB     = SRCB_B;
      ALU_SELECTOR = 3'd0;
      LOAD_ALU_OUT = 1'b0;
      LOAD_MDR     = 1'b0;
      WRITE_REG    = 1'b0;
      MEM_TO_REG   = M2R_ALU;
      case (state_q)
         RESET_ST: state_d = FETCH;
         FETCH: begin
            MEM_REQ = 1'b1;
            if (MEM_READY) begin
               IR_WIRE      = 1'b1;
               ALU_SRCA     = SRCA_PC;
               ALU_SRCB     = SRCB_4;
               ALU_SELECTOR = ALU_ADD;
               PC_WRITE     = 1'b1;
               PC_SRC       = PCS_ALU;
               state_d      = DECODE;
            end else if (mem_to) begin
               timeout_d = 1'b1;
               state_d   = TRAP;
            end
         end
         DECODE: begin
            // Branch target precomputed here while A/B are loaded
            LOAD_AB      = 1'b1;
            ALU_SRCA     = SRCA_PC;
            ALU_SRCB     = SRCB_IMM_SH1;
            ALU_SELECTOR = ALU_ADD;
            LOAD_ALU_OUT = 1'b1;
            case (opcode)
               OP_R:               state_d = EXEC_R;
               OP_I:               state_d = EXEC_I;
               OP_LOAD, OP_STORE:  state_d = ADDR;
               OP_BRANCH:          state_d = BRANCH;
               OP_LUI:             state_d = LUI;
               OP_JAL: begin
                  if (EN_JAL) state_d = JAL;
                  else begin
                     illegal_d = 1'b1;
                     state_d   = TRAP;
                  end
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = TRAP;
               end
            endcase
         end
         EXEC_R: begin
            ALU_SRCA = SRCA_A;
            ALU_SRCB = SRCB_B;
            if (funct7 == F7_ADD || funct7 == F7_SUB) begin
               ALU_SELECTOR = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
               LOAD_ALU_OUT = 1'b1;
               state_d      = WB_ALU;
            end else begin
               illegal_d = 1'b1;
               state_d   = TRAP;
            end
         end
         EXEC_I, ADDR, LUI: begin
            ALU_SRCA     = (state_q == LUI) ? SRCA_ZERO : SRCA_A;
            ALU_SRCB     = SRCB_IMM;
            ALU_SELECTOR = ALU_ADD;
            LOAD_ALU_OUT = 1'b1;
            if (state_q != ADDR)       state_d = WB_ALU;
            else if (opcode == OP_LOAD) state_d = MEM_RD;
            else                        state_d = MEM_WR;
         end
         WB_ALU: begin
            WRITE_REG  = 1'b1;
            MEM_TO_REG = M2R_ALU;
            state_d    = FETCH;
         end
         MEM_RD: begin
            MEM_REQ = 1'b1;
            if (MEM_READY) begin
               LOAD_MDR = 1'b1;
               state_d  = WB_MEM;
            end else if (mem_to) begin
               timeout_d = 1'b1;
               state_d   = TRAP;
            end
         end
         WB_MEM: begin
            WRITE_REG  = 1'b1;
            MEM_TO_REG = M2R_MDR;
            state_d    = FETCH;
         end
         MEM_WR: begin
            MEM_REQ = 1'b1;
            DMEM_RW = 1'b1;
            if (MEM_READY) state_d = FETCH;
            else if (mem_to) begin
               timeout_d = 1'b1;
               state_d   = TRAP;
            end
         end
         BRANCH: begin
            ALU_SRCA     = SRCA_A;
            ALU_SRCB     = SRCB_B;
            ALU_SELECTOR = ALU_SUB;
            state_d      = FETCH;
            if ((funct3 == 3'd0 && Igual) || (funct3 == 3'd1 && !Igual)) begin
               PC_WRITE = 1'b1;
               PC_SRC   = PCS_ALUOUT;
            end else if (funct3 > 3'd1) begin
               illegal_d = 1'b1;
               state_d   = TRAP;
            end
         end
         JAL: begin
            // PC already holds the return address (+4 applied in FETCH)
            WRITE_REG  = 1'b1;
            MEM_TO_REG = M2R_PC;
            PC_WRITE   = 1'b1;
            PC_SRC     = PCS_ALUOUT;
            state_d    = FETCH;
         end
         TRAP: begin
            PC_WRITE = 1'b1;
            PC_SRC   = PCS_TRAP;
            state_d  = FETCH;
         end
         default: state_d = RESET_ST;
      endcase
   end

   // State and sticky fault flags
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= RESET_ST;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_uc_multiciclo_param.sv
// Directed self-checking bench for the multicycle control unit.
module tb_uc_multiciclo_param;
   import uc_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] IR31_0;
   logic        Igual;
   logic        MEM_READY;
   logic        PC_WRITE;
   logic [1:0]  PC_SRC;
   logic        IR_WIRE;
   logic        MEM_REQ;
   logic        DMEM_RW;
   logic        LOAD_AB;
   logic [1:0]  ALU_SRCA;
   logic [1:0]  ALU_SRCB;
   logic [2:0]  ALU_SELECTOR;
   logic        LOAD_ALU_OUT;
   logic        LOAD_MDR;
   logic        WRITE_REG;
   logic [1:0]  MEM_TO_REG;
   logic [4:0]  ESTADO_ATUAL;
   logic        ILLEGAL;
   logic        MEM_TIMEOUT;

   int checks   = 0;
   int failures = 0;
   int wr_cnt;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_BADF = 32'h022081B3;
   localparam logic [31:0] I_LD   = 32'h0000B183;
   localparam logic [31:0] I_SD   = 32'h0030B023;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_BNE  = 32'h00209063;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic [20:0] outs;
   assign outs = {PC_WRITE, PC_SRC, IR_WIRE, MEM_REQ, DMEM_RW, LOAD_AB, ALU_SRCA,
                  ALU_SRCB, ALU_SELECTOR, LOAD_ALU_OUT, LOAD_MDR, WRITE_REG,
                  MEM_TO_REG, ILLEGAL, MEM_TIMEOUT};

   always #5 CLK = ~CLK;

   uc_multiciclo_param #(.XLEN(64), .MEM_TO_MAX(15), .EN_JAL(1'b1)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IR31_0(IR31_0), .Igual(Igual),
      .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC),
      .IR_WIRE(IR_WIRE), .MEM_REQ(MEM_REQ), .DMEM_RW(DMEM_RW),
      .LOAD_AB(LOAD_AB), .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB),
      .ALU_SELECTOR(ALU_SELECTOR), .LOAD_ALU_OUT(LOAD_ALU_OUT),
      .LOAD_MDR(LOAD_MDR), .WRITE_REG(WRITE_REG), .MEM_TO_REG(MEM_TO_REG),
      .ESTADO_ATUAL(ESTADO_ATUAL), .ILLEGAL(ILLEGAL), .MEM_TIMEOUT(MEM_TIMEOUT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to the low phase after the next rising edge
   task automatic nxt();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0; MEM_READY = 1'b0; Igual = 1'b0; IR31_0 = I_ADD;
      #1;
      chk("rst_state", ESTADO_ATUAL, RESET_ST);
      chk("rst_outs", outs, 0);
      @(negedge CLK);
      RESET_N = 1'b1; MEM_READY = 1'b1;

      // ADD: FETCH, DECODE, EXEC_R, WB_ALU
      nxt(); wr_cnt = 0;
      chk("add_fetch_st", ESTADO_ATUAL, FETCH);
      chk("add_fetch_ctl", {MEM_REQ, IR_WIRE, PC_WRITE, PC_SRC, ALU_SRCB, ALU_SELECTOR}, 11'b1_1_1_00_01_001);
      wr_cnt += int'(WRITE_REG);
      nxt();
      chk("add_dec_st", ESTADO_ATUAL, DECODE);
      chk("add_dec_ab", LOAD_AB, 1);
      wr_cnt += int'(WRITE_REG);
      nxt();
      chk("add_ex_st", ESTADO_ATUAL, EXEC_R);
      chk("add_ex_alu", {ALU_SELECTOR, LOAD_ALU_OUT}, 4'b001_1);
      wr_cnt += int'(WRITE_REG);
      nxt();
      chk("add_wb_st", ESTADO_ATUAL, WB_ALU);
      chk("add_wb_ctl", {WRITE_REG, MEM_TO_REG}, 3'b1_00);
      wr_cnt += int'(WRITE_REG);
      nxt();
      chk("add_back_fetch", ESTADO_ATUAL, FETCH);
      chk("add_wr_once", wr_cnt, 1);

      // SUB, then illegal funct7
      IR31_0 = I_SUB;
      nxt(); nxt();
      chk("sub_ex_st", ESTADO_ATUAL, EXEC_R);
      chk("sub_alu", ALU_SELECTOR, 2);
      nxt(); nxt();
      chk("sub_back_fetch", ESTADO_ATUAL, FETCH);
      IR31_0 = I_BADF;
      nxt(); nxt();
      chk("badf7_ex_noload", LOAD_ALU_OUT, 0);
      nxt();
      chk("badf7_trap_st", ESTADO_ATUAL, TRAP);
      chk("badf7_illegal", ILLEGAL, 1);
      chk("badf7_trap_pc", {PC_WRITE, PC_SRC}, 3'b1_10);
      nxt();
      chk("badf7_fetch", ESTADO_ATUAL, FETCH);

      // LD with three not-ready cycles in MEM_RD
      IR31_0 = I_LD;
      nxt(); nxt();
      chk("ld_addr_st", ESTADO_ATUAL, ADDR);
      MEM_READY = 1'b0;
      nxt();
      chk("ld_rd1_st", ESTADO_ATUAL, MEM_RD);
      chk("ld_rd1_ctl", {MEM_REQ, DMEM_RW, LOAD_MDR}, 3'b100);
      nxt(); nxt();
      chk("ld_rd3_ctl", {ESTADO_ATUAL, LOAD_MDR}, {MEM_RD, 1'b0});
      nxt();
      MEM_READY = 1'b1; #1;
      chk("ld_rd4_mdr", {ESTADO_ATUAL, LOAD_MDR}, {MEM_RD, 1'b1});
      nxt();
      chk("ld_wb_ctl", {ESTADO_ATUAL, WRITE_REG, MEM_TO_REG}, {WB_MEM, 3'b1_01});
      nxt();
      chk("ld_back_fetch", ESTADO_ATUAL, FETCH);

      // BEQ taken, BNE not taken / taken
      IR31_0 = I_BEQ; Igual = 1'b1;
      nxt(); nxt();
      chk("beq_st", ESTADO_ATUAL, BRANCH);
      chk("beq_taken", {PC_WRITE, PC_SRC, ALU_SELECTOR}, 6'b1_01_010);
      nxt();
      IR31_0 = I_BNE;
      nxt(); nxt();
      chk("bne_eq_not_taken", {ESTADO_ATUAL, PC_WRITE}, {BRANCH, 1'b0});
      Igual = 1'b0; #1;
      chk("bne_ne_taken", {PC_WRITE, PC_SRC}, 3'b1_01);
      nxt();
      chk("bne_back_fetch", ESTADO_ATUAL, FETCH);

      // JAL
      IR31_0 = I_JAL;
      nxt(); nxt();
      chk("jal_st", ESTADO_ATUAL, JAL);
      chk("jal_ctl", {WRITE_REG, MEM_TO_REG, PC_WRITE, PC_SRC}, 6'b1_10_1_01);
      nxt();

      // FETCH timeout after exactly 15 not-ready cycles
      MEM_READY = 1'b0; #1;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) nxt();
         chk("to_wait", {ESTADO_ATUAL, MEM_TIMEOUT}, {FETCH, 1'b0});
      end
      nxt();
      chk("to_trap_st", ESTADO_ATUAL, TRAP);
      chk("to_flag", {MEM_TIMEOUT, MEM_REQ, PC_WRITE, PC_SRC}, 5'b1_0_1_10);
      nxt();
      chk("to_fetch", ESTADO_ATUAL, FETCH);

      // Ready on the 15th cycle completes the fetch instead of timing out
      IR31_0 = I_SD;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) nxt();
      end
      nxt();
      MEM_READY = 1'b1; #1;
      chk("to_edge_ready", {ESTADO_ATUAL, IR_WIRE}, {FETCH, 1'b1});
      nxt();
      chk("to_edge_decode", ESTADO_ATUAL, DECODE);

      // SD waiting in MEM_WR, then asynchronous reset
      nxt();
      MEM_READY = 1'b0;
      nxt();
      chk("sd_wr_ctl", {ESTADO_ATUAL, MEM_REQ, DMEM_RW}, {MEM_WR, 2'b11});
      nxt();
      chk("sd_wr_hold", {ESTADO_ATUAL, MEM_REQ, DMEM_RW}, {MEM_WR, 2'b11});
      #2; RESET_N = 1'b0; #1;
      chk("arst_state", ESTADO_ATUAL, RESET_ST);
      chk("arst_outs", outs, 0);
      @(negedge CLK);
      RESET_N = 1'b1; MEM_READY = 1'b1; IR31_0 = I_BAD;
      nxt();
      chk("bad_fetch", ESTADO_ATUAL, FETCH);
      nxt(); nxt();
      chk("bad_trap", {ESTADO_ATUAL, ILLEGAL, PC_SRC}, {TRAP, 1'b1, 2'b10});
      nxt();
      chk("bad_sticky", {ESTADO_ATUAL, ILLEGAL}, {FETCH, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
